generic_vidmap_ctrl: RTL and testbench

Owns and sequences the virtual-to-physical hart ID mapping. Holds a programmable shadow map and an active map, validates each new map for duplicate VIDs, and applies it atomically. Round-robin arbitrates VID→PID translation requests from several requesters onto the single active inverse table, and translates a VID-indexed vector into a PID-indexed vector. Sits between the configuration/CSR path and the per-hart debug and trace consumers that need physical IDs.

---
 rtl/generic_vidmap_pkg.sv | 31 +++
 rtl/generic_vidmap_inv.sv | 24 ++
 rtl/generic_vidmap_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_generic_vidmap_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_vidmap_pkg.sv
// Shared types and helpers for the virtual-to-physical hart ID mapper.
package generic_vidmap_pkg;

   localparam int unsigned VidmapHarts = 8;
   localparam int unsigned VidmapIdxW  = (VidmapHarts == 1) ? 1 : $clog2(VidmapHarts);

   typedef struct packed {
      logic [VidmapIdxW-1:0] pid;
      logic                  mapped;
   } vidtopid_t;

   typedef struct packed {
      logic                  fuse;
      logic [VidmapIdxW-1:0] vid;
   } vidmap_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      APPLY = 2'd2
   } state_e;

   function automatic vidmap_entry_t ident_entry(input int unsigned i);
      ident_entry = '{fuse: 1'b1, vid: VidmapIdxW'(i)};
   endfunction

   function automatic vidtopid_t ident_inv(input int unsigned i);
      ident_inv = '{pid: VidmapIdxW'(i), mapped: 1'b1};
   endfunction

endpackage

// File: rtl/generic_vidmap_inv.sv
// Combinational inverse of a PID-indexed map: VID -> {pid, mapped}.
// Unfused PIDs contribute nothing; on duplicate VIDs the higher PID wins.
module generic_vidmap_inv
   import generic_vidmap_pkg::*;
#(
   parameter int unsigned NumHarts = VidmapHarts
) (
   input  vidmap_entry_t map_i [NumHarts],
   output vidtopid_t     inv_o [NumHarts]
);

   always_comb begin
      for (int unsigned v = 0; v < NumHarts; v++) begin
         inv_o[v] = '0;
      end
      // Ascending PID order lets later (higher) PIDs overwrite earlier ones.
      for (int unsigned p = 0; p < NumHarts; p++) begin
         if (map_i[p].fuse) begin
            inv_o[map_i[p].vid] = '{pid: VidmapIdxW'(p), mapped: 1'b1};
         end
      end
   end

endmodule

// File: rtl/generic_vidmap_ctrl.sv
// Shadow/active VID->PID map controller with round-robin translation port.
// Define VIDMAP_CTRL_DUP_CHECK_EN to validate each committed map for duplicate VIDs.
module generic_vidmap_ctrl
   import generic_vidmap_pkg::*;
#(
   parameter int unsigned NumHarts    = VidmapHarts,
   parameter int unsigned NumHartsIdx = (NumHarts == 1) ? 1 : $clog2(NumHarts),
   parameter int unsigned NumReq      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cfg_wr_valid,
   output logic                          cfg_wr_ready,
   input  logic [NumHartsIdx-1:0]        cfg_wr_pid,
   input  logic [NumHartsIdx-1:0]        cfg_wr_vid,
   input  logic                          cfg_wr_fuse,
   input  logic                          cfg_commit,
   output logic                          cfg_done,
   output logic                          cfg_err,
   input  logic [NumReq-1:0]             req_valid,
   input  logic [NumReq*NumHartsIdx-1:0] req_vid,
   output logic [NumReq-1:0]             req_ready,
   output logic                          rsp_valid,
   output logic [((NumReq == 1) ? 1 : $clog2(NumReq))-1:0] rsp_id,
   output logic [NumHartsIdx-1:0]        rsp_pid,
   output logic                          rsp_map_avail,
   input  logic [NumHarts-1:0]           vid_vector,
   output logic [NumHarts-1:0]           pid_vector
);

   localparam int unsigned ReqIdW = (NumReq == 1) ? 1 : $clog2(NumReq);

   state_e                  state_q, state_d;
   vidmap_entry_t           shadow_q [NumHarts];
   vidmap_entry_t           shadow_d [NumHarts];
   vidmap_entry_t           active_q [NumHarts];
   vidmap_entry_t           active_d [NumHarts];
   vidtopid_t               inv_q [NumHarts];
   vidtopid_t               inv_d [NumHarts];
   vidtopid_t               inv_shadow [NumHarts];
   logic [ReqIdW-1:0]       rr_ptr_q, rr_ptr_d;
   logic                    cfg_wr_ready_q, cfg_wr_ready_d;
   logic                    cfg_done_q, cfg_done_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [ReqIdW-1:0]       rsp_id_q, rsp_id_d;
   logic [NumHartsIdx-1:0]  rsp_pid_q, rsp_pid_d;
   logic                    rsp_map_avail_q, rsp_map_avail_d;
   logic [NumHarts-1:0]     pid_vector_q, pid_vector_d;
   logic [NumReq-1:0]       grant_c;
   logic [ReqIdW-1:0]       gnt_idx;
   logic                    gnt_any;
   logic [NumHartsIdx-1:0]  req_vid_a [NumReq];
   vidtopid_t               lookup;
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
   logic [NumHartsIdx-1:0]  chk_idx_q, chk_idx_d;
   logic                    cfg_err_q, cfg_err_d;
`endif

   generic_vidmap_inv #(.NumHarts(NumHarts)) u_inv (
      .map_i (shadow_q),
      .inv_o (inv_shadow)
   );

   for (genvar r = 0; r < NumReq; r++) begin : g_req_vid
      assign req_vid_a[r] = req_vid[r*NumHartsIdx +: NumHartsIdx];
   end

   // Config FSM: shadow writes, commit, optional duplicate scan, atomic apply.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      inv_d      = inv_q;
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
      chk_idx_d  = chk_idx_q;
      cfg_err_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (cfg_wr_ready_q && cfg_wr_valid) begin
               shadow_d[cfg_wr_pid] = '{fuse: cfg_wr_fuse, vid: VidmapIdxW'(cfg_wr_vid)};
            end
            if (cfg_wr_ready_q && cfg_commit) begin
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
               state_d   = CHECK;
               chk_idx_d = '0;
`else
               state_d   = APPLY;
`endif
            end
         end
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
         CHECK: begin
            if (cfg_err_q) begin
               state_d = IDLE;
            end else if (chk_idx_q == NumHartsIdx'(NumHarts - 1)) begin
               state_d = APPLY;
            end else begin
               chk_idx_d = chk_idx_q + NumHartsIdx'(1);
            end
         end
`endif
         APPLY: begin
            active_d = shadow_q;
            inv_d    = inv_shadow;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
      // Scan the entry the next CHECK cycle owns so cfg_err lands in that cycle.
      if (state_d == CHECK && shadow_d[chk_idx_d].fuse) begin
         for (int unsigned j = 0; j < NumHarts; j++) begin
            if (j > 32'(chk_idx_d) && shadow_d[j].fuse &&
                shadow_d[j].vid == shadow_d[chk_idx_d].vid) begin
               cfg_err_d = 1'b1;
            end
         end
      end
`endif
      cfg_done_d     = (state_d == APPLY);
      cfg_wr_ready_d = (state_d == IDLE);
   end

   // Round-robin grant, open only while the config path is idle.
   always_comb begin : p_arb
      int unsigned cand;
      cand    = 0;
      grant_c = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (cfg_wr_ready_q) begin
         for (int unsigned off = 0; off < NumReq; off++) begin
            cand = (32'(rr_ptr_q) + off) % NumReq;
            if (!gnt_any && req_valid[ReqIdW'(cand)]) begin
               gnt_any = 1'b1;
               gnt_idx = ReqIdW'(cand);
            end
         end
      end
      grant_c[gnt_idx] = gnt_any;
   end

   always_comb begin
      rr_ptr_d        = rr_ptr_q;
      rsp_valid_d     = gnt_any;
      rsp_id_d        = gnt_idx;
      rsp_pid_d       = '0;
      rsp_map_avail_d = 1'b0;
      lookup          = inv_q[req_vid_a[gnt_idx]];
      if (gnt_any) begin
         rr_ptr_d        = (gnt_idx == ReqIdW'(NumReq - 1)) ? '0 : gnt_idx + ReqIdW'(1);
         rsp_pid_d       = NumHartsIdx'(lookup.pid);
         rsp_map_avail_d = lookup.mapped && active_q[lookup.pid].fuse &&
                           (active_q[lookup.pid].vid == VidmapIdxW'(req_vid_a[gnt_idx]));
      end
   end

   always_comb begin
      pid_vector_d = '0;
      for (int unsigned k = 0; k < NumHarts; k++) begin
         if (inv_q[k].mapped) begin
            pid_vector_d[inv_q[k].pid] = vid_vector[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         for (int unsigned i = 0; i < NumHarts; i++) begin
            shadow_q[i] <= ident_entry(i);
            active_q[i] <= ident_entry(i);
            inv_q[i]    <= ident_inv(i);
         end
         rr_ptr_q        <= '0;
         cfg_wr_ready_q  <= 1'b0;
         cfg_done_q      <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_id_q        <= '0;
         rsp_pid_q       <= '0;
         rsp_map_avail_q <= 1'b0;
         pid_vector_q    <= '0;
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
         chk_idx_q       <= '0;
         cfg_err_q       <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         shadow_q        <= shadow_d;
         active_q        <= active_d;
         inv_q           <= inv_d;
         rr_ptr_q        <= rr_ptr_d;
         cfg_wr_ready_q  <= cfg_wr_ready_d;
         cfg_done_q      <= cfg_done_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_id_q        <= rsp_id_d;
         rsp_pid_q       <= rsp_pid_d;
         rsp_map_avail_q <= rsp_map_avail_d;
         pid_vector_q    <= pid_vector_d;
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
         chk_idx_q       <= chk_idx_d;
         cfg_err_q       <= cfg_err_d;
`endif
      end
   end

   assign cfg_wr_ready  = cfg_wr_ready_q;
   assign cfg_done      = cfg_done_q;
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
   assign cfg_err       = cfg_err_q;
`else
   assign cfg_err       = 1'b0;
`endif
   assign req_ready     = grant_c;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_pid       = rsp_pid_q;
   assign rsp_map_avail = rsp_map_avail_q;
   assign pid_vector    = pid_vector_q;

endmodule

// File: tb/tb_generic_vidmap_ctrl.sv
// Directed self-checking bench for generic_vidmap_ctrl (NumHarts=8, NumReq=4).
module tb_generic_vidmap_ctrl;

   localparam int unsigned NH = 8;
   localparam int unsigned NI = 3;
   localparam int unsigned NR = 4;
   localparam int unsigned RI = 2;
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
   localparam int ChkCyc = NH;
`else
   localparam int ChkCyc = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_wr_valid;
   logic          cfg_wr_ready;
   logic [NI-1:0] cfg_wr_pid;
   logic [NI-1:0] cfg_wr_vid;
   logic          cfg_wr_fuse;
   logic          cfg_commit;
   logic          cfg_done;
   logic          cfg_err;
   logic [NR-1:0] req_valid;
   logic [NR*NI-1:0] req_vid;
   logic [NR-1:0] req_ready;
   logic          rsp_valid;
   logic [RI-1:0] rsp_id;
   logic [NI-1:0] rsp_pid;
   logic          rsp_map_avail;
   logic [NH-1:0] vid_vector;
   logic [NH-1:0] pid_vector;

   int n_chk  = 0;
   int n_fail = 0;
   int rr_pid [4] = '{1, 4, 5, 7};

   always #5 clk = ~clk;

   generic_vidmap_ctrl #(.NumHarts(NH), .NumReq(NR)) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_wr_valid  (cfg_wr_valid),
      .cfg_wr_ready  (cfg_wr_ready),
      .cfg_wr_pid    (cfg_wr_pid),
      .cfg_wr_vid    (cfg_wr_vid),
      .cfg_wr_fuse   (cfg_wr_fuse),
      .cfg_commit    (cfg_commit),
      .cfg_done      (cfg_done),
      .cfg_err       (cfg_err),
      .req_valid     (req_valid),
      .req_vid       (req_vid),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_pid       (rsp_pid),
      .rsp_map_avail (rsp_map_avail),
      .vid_vector    (vid_vector),
      .pid_vector    (pid_vector)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int pid, input int vid, input logic fuse);
      cfg_wr_valid = 1'b1;
      cfg_wr_pid   = NI'(pid);
      cfg_wr_vid   = NI'(vid);
      cfg_wr_fuse  = fuse;
   endtask

   // Single requester r asks for vid; expects an immediate grant and response next cycle.
   task automatic req1(input string tag, input int r, input int vid, input int pid, input int avail);
      req_valid = NR'(1 << r);
      req_vid[r*NI +: NI] = NI'(vid);
      #1;
      chk({tag, "_grant"}, 32'(req_ready), 32'(1 << r));
      tick();
      req_valid = '0;
      chk({tag, "_rvalid"}, 32'(rsp_valid), 1);
      chk({tag, "_rid"}, 32'(rsp_id), 32'(r));
      chk({tag, "_rpid"}, 32'(rsp_pid), 32'(pid));
      chk({tag, "_avail"}, 32'(rsp_map_avail), 32'(avail));
   endtask

   // Commit (with any write already on the cfg port) and expect the map to be applied.
   task automatic commit_ok(input string tag);
      cfg_commit = 1'b1;
      tick();
      cfg_commit   = 1'b0;
      cfg_wr_valid = 1'b0;
      req_valid    = '1;
      #1;
      for (int i = 0; i < ChkCyc; i++) begin
         chk({tag, "_busy_done"}, 32'(cfg_done), 0);
         chk({tag, "_busy_err"}, 32'(cfg_err), 0);
         chk({tag, "_busy_gnt"}, 32'(req_ready), 0);
         chk({tag, "_busy_wrdy"}, 32'(cfg_wr_ready), 0);
         tick();
      end
      chk({tag, "_done"}, 32'(cfg_done), 1);
      chk({tag, "_apply_gnt"}, 32'(req_ready), 0);
      chk({tag, "_apply_wrdy"}, 32'(cfg_wr_ready), 0);
      req_valid = '0;
      tick();
      chk({tag, "_done_off"}, 32'(cfg_done), 0);
      chk({tag, "_idle_wrdy"}, 32'(cfg_wr_ready), 1);
   endtask

`ifdef VIDMAP_CTRL_DUP_CHECK_EN
   task automatic commit_err(input string tag, input int k);
      cfg_commit = 1'b1;
      tick();
      cfg_commit   = 1'b0;
      cfg_wr_valid = 1'b0;
      for (int i = 0; i < k; i++) begin
         chk({tag, "_pre_err"}, 32'(cfg_err), 0);
         tick();
      end
      chk({tag, "_err"}, 32'(cfg_err), 1);
      chk({tag, "_err_done"}, 32'(cfg_done), 0);
      tick();
      chk({tag, "_err_off"}, 32'(cfg_err), 0);
      chk({tag, "_no_done"}, 32'(cfg_done), 0);
      chk({tag, "_idle_wrdy"}, 32'(cfg_wr_ready), 1);
   endtask
`endif

   initial begin
      reset        = 1'b1;
      cfg_wr_valid = 1'b0;
      cfg_wr_pid   = '0;
      cfg_wr_vid   = '0;
      cfg_wr_fuse  = 1'b0;
      cfg_commit   = 1'b0;
      req_valid    = '0;
      req_vid      = '0;
      vid_vector   = '0;
      repeat (3) tick();
      chk("rst_wrdy", 32'(cfg_wr_ready), 0);
      chk("rst_rvalid", 32'(rsp_valid), 0);
      chk("rst_done", 32'(cfg_done), 0);
      chk("rst_err", 32'(cfg_err), 0);
      chk("rst_pidvec", 32'(pid_vector), 0);
      reset = 1'b0;
      tick();
      chk("idle_wrdy", 32'(cfg_wr_ready), 1);

      // Identity map out of reset
      req1("id_vid5", 0, 5, 5, 1);
      vid_vector = 8'hA5;
      tick();
      chk("id_pidvec", 32'(pid_vector), 32'h A5);

      // Swap pid0/pid3; second write shares the commit cycle
      wr(3, 0, 1'b1);
      tick();
      wr(0, 3, 1'b1);
      commit_ok("remap");
      req1("remap_vid0", 0, 0, 3, 1);
      req1("remap_vid3", 1, 3, 0, 1);
      vid_vector = 8'h01;
      tick();
      chk("remap_pidvec01", 32'(pid_vector), 32'h08);
      vid_vector = 8'h08;
      tick();
      chk("remap_pidvec08", 32'(pid_vector), 32'h01);

      // pid2 takes vid3, colliding with pid0
      wr(2, 3, 1'b1);
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
      commit_err("dup", 0);
      req1("dup_keep_vid3", 2, 3, 0, 1);
      req1("dup_keep_vid2", 3, 2, 2, 1);
`else
      commit_ok("dup");
      req1("dup_hi_vid3", 2, 3, 2, 1);
      req1("dup_hole_vid2", 3, 2, 0, 0);
`endif

      // Restore pid2, unfuse pid6
      wr(2, 2, 1'b1);
      tick();
      wr(6, 6, 1'b0);
      commit_ok("unfuse");
      req1("unfuse_vid6", 0, 6, 0, 0);
      vid_vector = 8'hFF;
      tick();
      chk("unfuse_pidvec", 32'(pid_vector), 32'h BF);

      // Align pointer to 0, then hold all requesters for 8 cycles
      req1("rr_align", 3, 7, 7, 1);
      req_vid   = {3'd7, 3'd5, 3'd4, 3'd1};
      req_valid = '1;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
         tick();
         chk("rr_rvalid", 32'(rsp_valid), 1);
         chk("rr_rid", 32'(rsp_id), 32'(i % 4));
         chk("rr_rpid", 32'(rsp_pid), 32'(rr_pid[i % 4]));
      end
      req_valid = '0;
      tick();
      chk("rr_idle_rvalid", 32'(rsp_valid), 0);

      // Reset while a commit is in flight
      cfg_commit = 1'b1;
`ifdef VIDMAP_CTRL_DUP_CHECK_EN
      tick();
      cfg_commit = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
`else
      reset = 1'b1;
      tick();
      cfg_commit = 1'b0;
`endif
      chk("rstmid_err", 32'(cfg_err), 0);
      chk("rstmid_done", 32'(cfg_done), 0);
      tick();
      reset = 1'b0;
      tick();
      chk("rstmid_done_after", 32'(cfg_done), 0);
      chk("rstmid_err_after", 32'(cfg_err), 0);
      chk("rstmid_wrdy", 32'(cfg_wr_ready), 1);
      req_vid   = {3'd0, 3'd0, 3'd6, 3'd2};
      req_valid = '1;
      #1;
      chk("rstmid_ptr0", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("rstmid_rid", 32'(rsp_id), 0);
      chk("rstmid_vid2", 32'(rsp_pid), 2);
      chk("rstmid_avail", 32'(rsp_map_avail), 1);
      req1("rstmid_vid6", 1, 6, 6, 1);
      req1("rstmid_vid3", 2, 3, 3, 1);
      vid_vector = 8'h40;
      tick();
      chk("rstmid_pidvec", 32'(pid_vector), 32'h40);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
